// File: rtl/mips_fetch_pkg.sv
// Shared types and width helpers for the MIPS instruction-fetch front end.
package mips_fetch_pkg;

  // Bytes per instruction word; also the sequential PC step.
  localparam int unsigned INSTR_BYTES = 4;

  // Slot storage widths; the fetch unit's ADDR_W/DATA_W must not exceed these.
  localparam int unsigned SLOT_ADDR_W = 32;
  localparam int unsigned SLOT_DATA_W = 32;

  // One prefetch queue entry: fetch address, returned word, and whether it has returned.
  typedef struct packed {
    logic [SLOT_ADDR_W-1:0] pc;
    logic [SLOT_DATA_W-1:0] data;
    logic                   filled;
  } fetch_slot_t;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  // Outstanding/stale request counter width: must represent 0..2*depth.
  function automatic int unsigned pend_width(input int unsigned depth);
    return $clog2(2 * depth + 1);
  endfunction

endpackage

// File: rtl/mips_fetch_queue.sv
// In-order prefetch ring: reserve at tail, fill oldest unfilled slot, pop at head, flush to empty.
module mips_fetch_queue
  import mips_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        srst_n_i,
  input  logic                        flush_i,
  input  logic                        reserve_i,
  input  logic [ADDR_W-1:0]           reserve_pc_i,
  input  logic                        fill_i,
  input  logic [DATA_W-1:0]           fill_data_i,
  input  logic                        pop_i,
  output logic [cnt_width(DEPTH)-1:0] count_o,
  output logic                        head_valid_o,
  output logic [ADDR_W-1:0]           head_pc_o,
  output logic [DATA_W-1:0]           head_data_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = cnt_width(DEPTH);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0] count_q, count_d;
  fetch_slot_t      slots_q [DEPTH];

  // Pointer and occupancy next state; a flush returns the ring to empty and wins over everything.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    fill_d  = fill_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      fill_d  = '0;
      count_d = '0;
    end else begin
      if (reserve_i) tail_d = tail_q + PTR_W'(1);
      if (fill_i)    fill_d = fill_q + PTR_W'(1);
      if (pop_i)     head_d = head_q + PTR_W'(1);
      count_d = count_q + CNT_W'(reserve_i) - CNT_W'(pop_i);
    end
  end

  // Pointer/occupancy registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!srst_n_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      fill_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      fill_q  <= fill_d;
      count_q <= count_d;
    end
  end

  // Slot payload: reserve records the pc at tail; a response lands in the oldest unfilled slot.
  always_ff @(posedge clk) begin
    if (srst_n_i && !flush_i) begin
      if (reserve_i) begin
        slots_q[tail_q] <= '{pc: SLOT_ADDR_W'(reserve_pc_i), data: '0, filled: 1'b0};
      end
      if (fill_i) begin
        slots_q[fill_q].data   <= SLOT_DATA_W'(fill_data_i);
        slots_q[fill_q].filled <= 1'b1;
      end
    end
  end

  assign count_o      = count_q;
  assign head_valid_o = (count_q != '0) && slots_q[head_q].filled;
  assign head_pc_o    = ADDR_W'(slots_q[head_q].pc);
  assign head_data_o  = DATA_W'(slots_q[head_q].data);

endmodule

// File: rtl/mips_fetch_unit.sv
// Decoupled instruction fetch: PC sequencing, request issue, stale-response tracking, redirect.
module mips_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [ADDR_W-1:0] inst_pc4
);

  localparam int unsigned CNT_W  = cnt_width(DEPTH);
  localparam int unsigned PEND_W = pend_width(DEPTH);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic [PEND_W-1:0] stale_q, stale_d;
  logic [CNT_W-1:0]  q_count;
  logic              req_fire;
  logic              rsp_drop;
  logic              rsp_fill;
  logic              pop;

  assign imem_req_valid = reset && !redirect_valid && (q_count < CNT_W'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  // Responses in a redirect cycle, or owed to a discarded stream, never reach the queue.
  assign rsp_drop       = imem_rsp_valid && (redirect_valid || (stale_q != '0));
  assign rsp_fill       = imem_rsp_valid && !rsp_drop;
  assign pop            = inst_valid && inst_ready && !redirect_valid;

  // Next fetch PC and in-flight bookkeeping; redirect converts everything outstanding into stale.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    pend_d     = pend_q + PEND_W'(req_fire) - PEND_W'(imem_rsp_valid);
    stale_d    = stale_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ~ADDR_W'(INSTR_BYTES - 1);
      stale_d    = pend_q - PEND_W'(imem_rsp_valid);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + ADDR_W'(INSTR_BYTES);
      if (imem_rsp_valid && (stale_q != '0)) stale_d = stale_q - PEND_W'(1);
    end
  end

  // Fetch PC and counters with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      pend_q     <= '0;
      stale_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pend_q     <= pend_d;
      stale_q    <= stale_d;
    end
  end

  mips_fetch_queue #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_queue (
    .clk          (clk),
    .srst_n_i     (reset),
    .flush_i      (redirect_valid),
    .reserve_i    (req_fire),
    .reserve_pc_i (fetch_pc_q),
    .fill_i       (rsp_fill),
    .fill_data_i  (imem_rsp_data),
    .pop_i        (pop),
    .count_o      (q_count),
    .head_valid_o (inst_valid),
    .head_pc_o    (inst_pc),
    .head_data_o  (inst_data)
  );

  assign inst_pc4 = inst_pc + ADDR_W'(INSTR_BYTES);

endmodule

// File: doc/mips_fetch_unit.md
# mips_fetch_unit

Parametrised instruction-fetch front end for the MIPS core. It replaces the bare PC register, PC+4 adder and direct instruction-memory read with a decoupled fetch stage that has a valid/ready request/response interface to instruction memory, a DEPTH-entry in-order prefetch queue, and a redirect port. The branch/jump/jr next-PC logic drives the redirect port, and decode consumes from the instruction port. The block tolerates arbitrary memory latency and keeps multiple requests in flight.

## Interface
Parameters:
- ADDR_W, 32, PC / memory address width
- DATA_W, 32, instruction word width
- DEPTH, 4, prefetch queue slots; power of two, ≥2
- RESET_PC, 0, first fetch address after reset; bits [1:0] must be 0

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-low; state clears on any edge where reset=0
- imem_req_valid  out  1  fetch request
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  ADDR_W  word-aligned fetch address
- imem_rsp_valid  in  1  response data valid; responses arrive in request order, one per accepted request, and cannot be back-pressured
- imem_rsp_data  in  DATA_W  instruction word
- redirect_valid  in  1  discard stream, restart at redirect_pc
- redirect_pc  in  ADDR_W  new PC; bits [1:0] ignored, forced to 00
- inst_valid  out  1  head instruction available
- inst_ready  in  1  decode consumes head
- inst_data  out  DATA_W  head instruction
- inst_pc  out  ADDR_W  head PC
- inst_pc4  out  ADDR_W  inst_pc+4, mod 2^ADDR_W

## Operation
- State:
  - fetch_pc
  - queue of DEPTH slots {pc, data, filled}, with head/tail pointers and count
  - pend: accepted requests not yet answered, 0..2·DEPTH
  - stale: pending responses to discard
- Reset values: fetch_pc=RESET_PC; count=pend=stale=0; inst_valid=0; imem_req_valid=0 in every cycle with reset=0.
- Request:
  - imem_req_valid = reset & !redirect_valid & (count<DEPTH).
  - imem_req_addr = fetch_pc.
- Handshake (valid&ready): reserve tail slot with pc=fetch_pc and filled=0; fetch_pc += 4 (wraps); pend++.
- Response:
  - If stale>0: drop the data, stale--.
  - Otherwise write data into the oldest unfilled slot and set filled=1.
  - pend-- in both cases.
- Output:
  - inst_valid = count>0 & head.filled.
  - inst_data, inst_pc and inst_pc4 come from the head slot.
  - inst_valid&inst_ready pops the head; the slot becomes free next cycle.
- Redirect (priority over all else):
  - fetch_pc ← {redirect_pc[ADDR_W-1:2],2'b00}.
  - Queue flushes (count=0), and any pop in the same cycle is ignored.
  - stale ← pend − (imem_rsp_valid ? 1 : 0). A response arriving in the redirect cycle is dropped.
  - No request is issued in the redirect cycle.
- A pop is allowed on an unfilled head: never (inst_valid=0).

## Timing
- Redirect at cycle t → imem_req_valid=1 with addr=redirect_pc at t+1 (if reset high).
- Request accepted at t, response at t+k → inst_valid at t+k+1 if that slot is the head.
- Slot freed by a pop at t is usable for a request at t+1.
- With 1-cycle memory and DEPTH≥4, the sustained rate is 1 instruction/cycle.
- Reset low mid-stream: everything clears at that edge. Late responses from before reset are not tracked; the memory must be reset together with this block.

## Structure
- Package mips_fetch_pkg holds:
  - INSTR_BYTES=4
  - typedef fetch_slot_t {pc, data, filled}
  - the clog2-based width constants for count/pend/stale
- Sub-module mips_fetch_queue implements reserve/fill/pop/flush over DEPTH slots with circular pointers; count has log2(DEPTH)+1 bits.
- Top level holds fetch_pc, pend/stale and request logic.

## Test plan
- Reset held low 3 cycles with random inputs → imem_req_valid=0, inst_valid=0; after release, request addresses 0x0, 0x4, 0x8.
- 1-cycle memory, inst_ready=1, DEPTH=4 → one instruction/cycle after fill; inst_pc 0,4,8…; inst_pc4=inst_pc+4.
- inst_ready=0 → exactly 4 requests accepted, then imem_req_valid=0; inst_ready=1 → instructions in PC order, requests resume.
- 3-cycle memory, redirect_pc=0x40 with 2 responses pending → next request 0x40; both stale responses dropped; first inst_pc=0x40.
- Redirect coinciding with a response and a pop, redirect_pc=0x43 → response dropped, queue empty, next request 0x40.
- RESET_PC=0xFFFF_FFF8 → requests 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; inst_pc4 of the second = 0x0.
